bcd_word_scanner: RTL and testbench



---
 rtl/bcd_word_scanner_pkg.sv | 13 +
 rtl/bcd_digit_check.sv | 13 +
 rtl/bcd_word_scanner.sv | 124 ++++++++++++
 tb/tb_bcd_word_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_word_scanner_pkg.sv
// Shared definitions for the BCD word scanner: FSM states and digit constants.
package bcd_word_scanner_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] BCD_SANITISE = 4'h0;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational single-digit BCD checker; invalid digits are replaced by the sanitise value.
module bcd_digit_check
  import bcd_word_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic       valid,
  output logic [3:0] clean
);

  assign valid = (digit <= BCD_MAX);
  assign clean = valid ? digit : BCD_SANITISE;

endmodule

// File: rtl/bcd_word_scanner.sv
// Validates and sanitises a packed BCD word one digit per clock using one shared checker.
module bcd_word_scanner
  import bcd_word_scanner_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [IDX_W-1:0]      out_err_idx,
  output logic [CNT_W-1:0]      out_err_cnt
);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_idx_q, err_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  init_q;

  logic [3:0] cur_digit;
  logic       cur_valid;
  logic [3:0] cur_clean;

  // Digit selected by the scan index feeds the single shared checker.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = word_q[i*4 +: 4];
    end
  end

  bcd_digit_check u_check (
    .digit (cur_digit),
    .valid (cur_valid),
    .clean (cur_clean)
  );

  assign in_ready  = init_q && (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    res_d     = res_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          word_d    = in_data;
          res_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) res_d[i*4 +: 4] = cur_clean;
        end
        if (!cur_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!err_q) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      word_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      cnt_q     <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      res_q     <= res_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      cnt_q     <= cnt_d;
      init_q    <= 1'b1;
    end
  end

  assign out_data    = res_q;
  assign out_err     = err_q;
  assign out_err_idx = err_idx_q;
  assign out_err_cnt = cnt_q;

endmodule

// File: tb/tb_bcd_word_scanner.sv
// Randomised and directed bench for bcd_word_scanner against an arithmetic reference model.
module tb_bcd_word_scanner;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 3;
  localparam int TMO    = 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       out_data;
  logic              out_err;
  logic [IDX_W-1:0]  out_err_idx;
  logic [CNT_W-1:0]  out_err_cnt;

  int checks = 0;
  int errors = 0;

  bcd_word_scanner #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_err_idx (out_err_idx),
    .out_err_cnt (out_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: examine each digit arithmetically, lowest index first.
  function automatic void ref_model(input logic [15:0] w, output logic [15:0] data,
                                    output logic err, output int idx, output int cnt);
    int d;
    data = '0; err = 1'b0; idx = 0; cnt = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((w >> (4 * i)) & 16'hF);
      if (d > 9) begin
        if (!err) idx = i;
        err = 1'b1;
        cnt++;
      end else begin
        data = data | 16'(d << (4 * i));
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a word, waits for the result, captures it and completes the handshake.
  task automatic transact(input logic [15:0] w, output logic [15:0] data, output logic err,
                          output int idx, output int cnt, output int lat, output bit tmo);
    int n;
    tmo = 1'b0;
    in_data = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin
      step();
      n++;
    end
    if (!in_ready) tmo = 1'b1;
    step();
    in_valid = 1'b0;
    in_data = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      step();
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    data = out_data;
    err = out_err;
    idx = int'(out_err_idx);
    cnt = int'(out_err_cnt);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, out_data, out_err, out_err_idx, out_err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h e=%b i=%0d c=%0d want all 0",
               in_ready, out_valid, out_data, out_err, out_err_idx, out_err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_first_edge got %b want 1", in_ready);
    end
  endtask

  task automatic run_and_check(input logic [15:0] w, input string name);
    logic [15:0] d, ed;
    logic e, ee;
    int i, c, ei, ec, lat;
    bit tmo;
    ref_model(w, ed, ee, ei, ec);
    transact(w, d, e, i, c, lat, tmo);
    checks++;
    if (tmo || lat != DIGITS) begin
      errors++;
      $display("FAIL %s_latency word=%h got %0d (timeout=%0d) want %0d", name, w, lat, tmo,
               DIGITS);
    end
    checks++;
    if (d !== ed || e !== ee || i != ei || c != ec) begin
      errors++;
      $display("FAIL %s_result word=%h got d=%h e=%b i=%0d c=%0d want d=%h e=%b i=%0d c=%0d",
               name, w, d, e, i, c, ed, ee, ei, ec);
    end
  endtask

  task automatic test_directed();
    logic [15:0] words [4] = '{16'h1234, 16'h12A4, 16'hFFFF, 16'h9A09};
    foreach (words[k]) run_and_check(words[k], "directed");
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int k = 0; k < 24; k++) begin
      w = 16'($urandom);
      // Bias toward mostly-valid words so single and sparse errors are common.
      for (int j = 0; j < DIGITS; j++) begin
        if ($urandom_range(0, 2) != 0) w[j*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_and_check(w, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0, ed;
    logic e0, ee;
    int n, ei, ec;
    bit stable, rdy_low;
    in_data = 16'h3A71;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin step(); n++; end
    step();
    in_data = 16'h5555;
    n = 0;
    while (!out_valid && n < TMO) begin step(); n++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_out_valid got 0 want 1");
    end
    ref_model(16'h3A71, ed, ee, ei, ec);
    d0 = out_data;
    e0 = out_err;
    stable = 1'b1;
    rdy_low = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!out_valid || out_data !== ed || out_err !== ee || int'(out_err_idx) != ei ||
          int'(out_err_cnt) != ec) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    checks++;
    if (!stable || d0 !== ed || e0 !== ee) begin
      errors++;
      $display("FAIL bp_hold got d=%h e=%b i=%0d c=%0d want d=%h e=%b i=%0d c=%0d", out_data,
               out_err, out_err_idx, out_err_cnt, ed, ee, ei, ec);
    end
    checks++;
    if (!rdy_low) begin
      errors++;
      $display("FAIL bp_in_ready got 1 want 0 while result pending");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_handshake got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_5555 got rdy=%b want 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < TMO) begin step(); n++; end
    checks++;
    if (n != DIGITS || out_data !== 16'h5555 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_word got lat=%0d d=%h e=%b want lat=%0d d=5555 e=0", n,
               out_data, out_err, DIGITS);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int n;
    in_data = 16'hBB11;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin step(); n++; end
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_err, out_err_idx, out_err_cnt} !== '0) begin
      errors++;
      $display("FAIL midscan_reset got rdy=%b v=%b d=%h e=%b i=%0d c=%0d want all 0",
               in_ready, out_valid, out_data, out_err, out_err_idx, out_err_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midscan_no_stale_result got %0d valid cycles want 0", n);
    end
    run_and_check(16'h0007, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
